// File: rtl/synchronous_fifo_reader.sv
// synchronous_fifo_reader
// Drains a first-word-fall-through FIFO egress port and emits fixed-length
// packets on a valid/ready stream with tlast. A normal packet only starts once
// the FIFO already holds the whole packet; a flush pulse emits the residue.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   fifo_egr_enable    pop strobe to the FIFO (combinational, equals load)
//   fifo_egr_data      FWFT head word, valid when !fifo_egr_empty
//   fifo_egr_empty     FIFO empty flag
//   fifo_fill_level    registered FIFO fill level
//   mst_tvalid/tready/tdata/tlast  output stream
//   cr_enable          allow normal burst starts
//   cr_burst_length    beats per packet, 0 disables normal starts
//   cr_flush           one-cycle pulse: emit residual contents as a short packet
//   sr_busy            FSM not idle or an output beat is pending
//   sr_burst_count     completed packets (tlast handshakes), wraps at 2^32
module synchronous_fifo_reader #(
    parameter int DATA_WIDTH_P  = -1,
    parameter int ADDR_WIDTH_P  = -1,
    parameter int BURST_WIDTH_P = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     fifo_egr_enable,
    input  logic [DATA_WIDTH_P-1:0]  fifo_egr_data,
    input  logic                     fifo_egr_empty,
    input  logic [ADDR_WIDTH_P:0]    fifo_fill_level,
    output logic                     mst_tvalid,
    input  logic                     mst_tready,
    output logic [DATA_WIDTH_P-1:0]  mst_tdata,
    output logic                     mst_tlast,
    input  logic                     cr_enable,
    input  logic [BURST_WIDTH_P-1:0] cr_burst_length,
    input  logic                     cr_flush,
    output logic                     sr_busy,
    output logic [31:0]              sr_burst_count
);

    // Length/beat counters must hold both a burst length and a fill level.
    localparam int unsigned LEN_W = (BURST_WIDTH_P > ADDR_WIDTH_P + 1) ?
                                    unsigned'(BURST_WIDTH_P) : unsigned'(ADDR_WIDTH_P + 1);

    typedef enum logic [0:0] {
        IDLE_S  = 1'b0,
        BURST_S = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        beat_q, beat_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [DATA_WIDTH_P-1:0] tdata_q, tdata_d;
    logic [31:0]             count_q, count_d;
    logic                    busy_q, busy_d;

    logic [LEN_W-1:0]        fill_ext;
    logic [LEN_W-1:0]        blen_ext;
    logic                    load;
    logic                    last_beat;

    // Zero-extended operands so all comparisons are unsigned at a common width.
    assign fill_ext  = LEN_W'(fifo_fill_level);
    assign blen_ext  = LEN_W'(cr_burst_length);

    // Pop/load whenever bursting, data is present and the output slot frees up.
    assign load      = (state_q == BURST_S) && !fifo_egr_empty && (!tvalid_q || mst_tready);
    assign last_beat = (beat_q == len_q - LEN_W'(1));

    assign fifo_egr_enable = load;

    // Next-state, counters and output register.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        beat_d   = beat_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        count_d  = count_q;

        case (state_q)
            IDLE_S: begin
                // Flush wins over a normal start in the same cycle.
                if (cr_flush && (fill_ext != '0)) begin
                    state_d = BURST_S;
                    beat_d  = '0;
                    len_d   = ((blen_ext == '0) || (fill_ext < blen_ext)) ? fill_ext : blen_ext;
                end else if (cr_enable && (blen_ext != '0) && (fill_ext >= blen_ext)) begin
                    state_d = BURST_S;
                    beat_d  = '0;
                    len_d   = blen_ext;
                end
            end
            BURST_S: begin
                // Underrun simply stalls here; len/beat are held until data returns.
                if (load) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d = IDLE_S;
                    end
                end
            end
            default: state_d = IDLE_S;
        endcase

        if (load) begin
            tdata_d  = fifo_egr_data;
            tvalid_d = 1'b1;
            tlast_d  = last_beat;
        end else if (tvalid_q && mst_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        if (tvalid_q && mst_tready && tlast_q) begin
            count_d = count_q + 32'd1;
        end

        busy_d = (state_d != IDLE_S) || tvalid_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE_S;
            len_q    <= '0;
            beat_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    assign mst_tvalid     = tvalid_q;
    assign mst_tlast      = tlast_q;
    assign mst_tdata      = tdata_q;
    assign sr_busy        = busy_q;
    assign sr_burst_count = count_q;

endmodule

// File: tb/tb_synchronous_fifo_reader.sv
// Directed bench for synchronous_fifo_reader with a small FWFT FIFO model and
// a stream capture buffer. Inputs change on the falling edge; outputs are
// sampled on the falling edge.
module tb_synchronous_fifo_reader;

    logic        clk;
    logic        rst;
    logic        fifo_egr_enable;
    logic [7:0]  fifo_egr_data;
    logic        fifo_egr_empty;
    logic [4:0]  fifo_fill_level;
    logic        mst_tvalid;
    logic        mst_tready;
    logic [7:0]  mst_tdata;
    logic        mst_tlast;
    logic        cr_enable;
    logic [7:0]  cr_burst_length;
    logic        cr_flush;
    logic        sr_busy;
    logic [31:0] sr_burst_count;

    synchronous_fifo_reader #(
        .DATA_WIDTH_P  (8),
        .ADDR_WIDTH_P  (4),
        .BURST_WIDTH_P (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_egr_enable (fifo_egr_enable),
        .fifo_egr_data   (fifo_egr_data),
        .fifo_egr_empty  (fifo_egr_empty),
        .fifo_fill_level (fifo_fill_level),
        .mst_tvalid      (mst_tvalid),
        .mst_tready      (mst_tready),
        .mst_tdata       (mst_tdata),
        .mst_tlast       (mst_tlast),
        .cr_enable       (cr_enable),
        .cr_burst_length (cr_burst_length),
        .cr_flush        (cr_flush),
        .sr_busy         (sr_busy),
        .sr_burst_count  (sr_burst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: fill level is the registered occupancy.
    logic [7:0]  mem [0:63];
    logic [5:0]  wr_ptr = '0;
    logic [5:0]  rd_ptr = '0;
    logic        push_en;
    logic [7:0]  push_data;
    logic        ovr_en;
    logic [4:0]  ovr_val;
    int          pops = 0;

    logic [5:0]  occ;
    assign occ             = wr_ptr - rd_ptr;
    assign fifo_egr_empty  = (occ == 6'd0);
    assign fifo_egr_data   = mem[rd_ptr];
    assign fifo_fill_level = ovr_en ? ovr_val : 5'(occ);

    // Stream capture: {tlast, tdata} and cycle stamp of every handshake.
    logic [8:0]  cap_data [0:63];
    int          cap_cyc  [0:63];
    int          cap_n = 0;
    int          cyc   = 0;

    always @(posedge clk) begin
        if (fifo_egr_enable && !fifo_egr_empty) begin
            rd_ptr <= rd_ptr + 6'd1;
            pops   <= pops + 1;
        end
        if (push_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 6'd1;
        end
        if (!rst && mst_tvalid && mst_tready) begin
            cap_data[6'(cap_n)] <= {mst_tlast, mst_tdata};
            cap_cyc[6'(cap_n)]  <= cyc;
            cap_n               <= cap_n + 1;
        end
        cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_words(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            push_en   = 1'b1;
            push_data = 8'(first + 8'(i));
            @(negedge clk);
        end
        push_en = 1'b0;
    endtask

    task automatic flush_pulse();
        cr_flush = 1'b1;
        @(negedge clk);
        cr_flush = 1'b0;
    endtask

    task automatic wait_caps(input string tag, input int target, input int budget);
        int k = 0;
        while (cap_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(cap_n), 32'(target));
    endtask

    // Expected packet: consecutive words from 'first', tlast only on the final beat.
    task automatic check_beats(input string tag, input int b, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_beat%0d", tag, i), 32'(cap_data[6'(b + i)]),
                32'({(i == n - 1), 8'(first + 8'(i))}));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         pops0;
        logic [3:0] pat;
        logic       prev_ok;
        logic       prev_valid;
        logic       prev_ready;
        logic [7:0] prev_data;
        logic       prev_last;

        rst             = 1'b1;
        push_en         = 1'b0;
        push_data       = '0;
        ovr_en          = 1'b0;
        ovr_val         = '0;
        mst_tready      = 1'b1;
        cr_enable       = 1'b0;
        cr_burst_length = '0;
        cr_flush        = 1'b0;
        cycles(2);

        // Reset state
        chk("rst_tvalid", 32'(mst_tvalid), 32'd0);
        chk("rst_tlast", 32'(mst_tlast), 32'd0);
        chk("rst_busy", 32'(sr_busy), 32'd0);
        chk("rst_count", sr_burst_count, 32'd0);
        chk("rst_pop", 32'(fifo_egr_enable), 32'd0);
        rst = 1'b0;
        cycles(1);

        // Two back-to-back length-4 packets from 8 buffered words
        cr_burst_length = 8'd4;
        push_words(8'h10, 8);
        base      = cap_n;
        cr_enable = 1'b1;
        wait_caps("t1_caps", base + 8, 60);
        check_beats("t1_p0", base, 8'h10, 4);
        check_beats("t1_p1", base + 4, 8'h14, 4);
        chk("t1_inburst_gap", 32'(cap_cyc[6'(base + 1)] - cap_cyc[6'(base)]), 32'd1);
        chk("t1_packet_gap", 32'(cap_cyc[6'(base + 4)] - cap_cyc[6'(base + 3)]), 32'd2);
        cycles(2);
        chk("t1_count", sr_burst_count, 32'd2);
        chk("t1_fifo_empty", 32'(fifo_egr_empty), 32'd1);
        chk("t1_busy", 32'(sr_busy), 32'd0);

        // Short FIFO never starts a normal burst; flush drains it
        push_words(8'h20, 3);
        pops0 = pops;
        base  = cap_n;
        cycles(20);
        chk("t2_no_pop", 32'(pops), 32'(pops0));
        chk("t2_no_valid", 32'(mst_tvalid), 32'd0);
        flush_pulse();
        wait_caps("t2_caps", base + 3, 30);
        check_beats("t2", base, 8'h20, 3);
        cycles(2);
        chk("t2_count", sr_burst_count, 32'd3);
        chk("t2_fifo_empty", 32'(fifo_egr_empty), 32'd1);

        // Sink back-pressure with tready pattern 1,0,0,1
        cr_enable = 1'b0;
        push_words(8'h30, 4);
        pops0     = pops;
        base      = cap_n;
        cr_enable = 1'b1;
        pat       = 4'b1001;
        prev_ok   = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
        prev_data  = '0;
        prev_last  = 1'b0;
        for (int k = 0; k < 60 && cap_n < base + 4; k++) begin
            @(negedge clk);
            if (prev_ok && prev_valid && !prev_ready) begin
                chk("t3_stall_valid", 32'(mst_tvalid), 32'd1);
                chk("t3_stall_data", 32'(mst_tdata), 32'(prev_data));
                chk("t3_stall_last", 32'(mst_tlast), 32'(prev_last));
            end
            prev_ok    = 1'b1;
            prev_valid = mst_tvalid;
            prev_data  = mst_tdata;
            prev_last  = mst_tlast;
            mst_tready = pat[2'(k)];
            prev_ready = mst_tready;
        end
        mst_tready = 1'b1;
        chk("t3_caps", 32'(cap_n), 32'(base + 4));
        check_beats("t3", base, 8'h30, 4);
        cycles(2);
        chk("t3_pops", 32'(pops - pops0), 32'd4);
        chk("t3_count", sr_burst_count, 32'd4);

        // Fill level overstates occupancy: burst waits for data, never truncates
        cr_enable = 1'b0;
        push_words(8'h40, 2);
        base      = cap_n;
        ovr_en    = 1'b1;
        ovr_val   = 5'd4;
        cr_enable = 1'b1;
        cycles(1);
        ovr_en    = 1'b0;
        cycles(10);
        chk("t4_partial_caps", 32'(cap_n - base), 32'd2);
        chk("t4_underrun_valid", 32'(mst_tvalid), 32'd0);
        chk("t4_underrun_busy", 32'(sr_busy), 32'd1);
        push_words(8'h42, 2);
        wait_caps("t4_caps", base + 4, 30);
        check_beats("t4", base, 8'h40, 4);
        cycles(2);
        chk("t4_count", sr_burst_count, 32'd5);
        chk("t4_idle", 32'(sr_busy), 32'd0);

        // Reset during beat 2 of an 8-beat burst
        cr_enable       = 1'b0;
        cr_burst_length = 8'd8;
        push_words(8'h50, 8);
        base      = cap_n;
        cr_enable = 1'b1;
        cycles(3);
        chk("t5_beat1_done", 32'(cap_n - base), 32'd1);
        chk("t5_beat2_held", 32'(mst_tdata), 32'h51);
        rst = 1'b1;
        cycles(1);
        chk("t5_rst_tvalid", 32'(mst_tvalid), 32'd0);
        chk("t5_rst_busy", 32'(sr_busy), 32'd0);
        chk("t5_rst_count", sr_burst_count, 32'd0);
        chk("t5_fifo_left", 32'(occ), 32'd5);
        rst = 1'b0;
        push_words(8'h58, 2);
        cycles(5);
        chk("t5_wait_valid", 32'(mst_tvalid), 32'd0);
        chk("t5_wait_busy", 32'(sr_busy), 32'd0);
        base = cap_n;
        push_words(8'h5A, 1);
        wait_caps("t5_caps", base + 8, 40);
        check_beats("t5", base, 8'h53, 8);
        cycles(2);
        chk("t5_count", sr_burst_count, 32'd1);

        // Burst length 0: no normal starts, flush emits everything
        cr_burst_length = 8'd0;
        push_words(8'h60, 5);
        base = cap_n;
        cycles(10);
        chk("t6_no_valid", 32'(mst_tvalid), 32'd0);
        chk("t6_no_busy", 32'(sr_busy), 32'd0);
        flush_pulse();
        wait_caps("t6_caps", base + 5, 30);
        check_beats("t6", base, 8'h60, 5);
        cycles(2);
        chk("t6_count", sr_burst_count, 32'd2);
        chk("t6_fifo_empty", 32'(fifo_egr_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
